// File: rtl/aes128_iter_core_if.sv
// Block-level handshake bundle for the iterative AES-128 core: plaintext/key in, ciphertext out.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Signals: in_valid, in_ready, in_data[127:0], in_key[127:0], out_valid, out_ready, out_data[127:0].
// The slave modport is the core's view; the master modport is the source/sink's view.
interface aes128_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor; ROUNDS_PER_CYCLE rounds per clock, round keys expanded on the fly.
// Latency: accept edge to out_valid is PASSES+1 edges (PASSES+2 cycles counting the accept cycle).
// Backpressure: in_ready only in IDLE; ciphertext held in DONE until out_ready.
// Ports: clock, reset (sync, active-high), bus (slave modport of aes128_iter_core_if), busy (INIT/ROUND).
// Optional macro AES128_ITER_STATS_EN adds blk_count[31:0], a wrapping count of ciphertext handoffs.
module aes128_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    aes128_iter_core_if.slave bus,
    output logic              busy
`ifdef AES128_ITER_STATS_EN
    ,
    output logic [31:0]       blk_count
`endif
);
    localparam int PASSES = 10 / ROUNDS_PER_CYCLE;

    generate
        if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
            ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
            $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
    endgenerate

    // Forward S-box, byte 0x00 in the leftmost 8 bits.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} fsm_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: output byte (r,c) takes input byte (r,(c+r)%4).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        // RotWord + SubWord on word 3, then Rcon into the top byte.
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] state_q, key_q;
    logic         in_ready_q, out_valid_q;
    logic [127:0] out_data_q;

    logic [127:0] s_w, k_w, sr_w;
    logic [7:0]   r_w;

    // Chain of ROUNDS_PER_CYCLE rounds; the last AES round (global index 9) skips MixColumns.
    always_comb begin
        s_w  = state_q;
        k_w  = key_q;
        r_w  = rcon;
        sr_w = '0;
        for (int l = 0; l < ROUNDS_PER_CYCLE; l++) begin
            k_w  = next_key(k_w, r_w);
            r_w  = xtime(r_w);
            sr_w = sub_shift(s_w);
            if (int'(cnt) * ROUNDS_PER_CYCLE + l == 9) s_w = sr_w ^ k_w;
            else                                        s_w = mix_cols(sr_w) ^ k_w;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm         <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy        <= 1'b0;
            cnt         <= '0;
            rcon        <= 8'h01;
            state_q     <= '0;
            key_q       <= '0;
`ifdef AES128_ITER_STATS_EN
            blk_count   <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: if (bus.in_valid) begin
                    state_q    <= bus.in_data;
                    key_q      <= bus.in_key;
                    in_ready_q <= 1'b0;
                    busy       <= 1'b1;
                    fsm        <= INIT;
                end
                INIT: begin
                    state_q <= state_q ^ key_q;
                    rcon    <= 8'h01;
                    cnt     <= '0;
                    fsm     <= ROUND;
                end
                ROUND: begin
                    state_q <= s_w;
                    key_q   <= k_w;
                    rcon    <= r_w;
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'(PASSES - 1)) begin
                        out_data_q  <= s_w;
                        out_valid_q <= 1'b1;
                        busy        <= 1'b0;
                        fsm         <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    fsm         <= IDLE;
`ifdef AES128_ITER_STATS_EN
                    blk_count   <= blk_count + 32'd1;
`endif
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: three instances (1, 2 and 10 rounds per clock) share clock and reset.
// Latency is counted with the accept cycle as cycle 1, so RPC=1 reports 12.
// Outputs are sampled 1 time unit after the rising edge, where inputs are also changed.
module tb_aes128_iter_core;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    aes128_iter_core_if b1 ();
    aes128_iter_core_if b2 ();
    aes128_iter_core_if b10 ();
    logic busy1, busy2, busy10;
`ifdef AES128_ITER_STATS_EN
    logic [31:0] cnt1, cnt2, cnt10;
`endif

    aes128_iter_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clock(clock), .reset(reset), .bus(b1), .busy(busy1)
`ifdef AES128_ITER_STATS_EN
        , .blk_count(cnt1)
`endif
    );
    aes128_iter_core #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clock(clock), .reset(reset), .bus(b2), .busy(busy2)
`ifdef AES128_ITER_STATS_EN
        , .blk_count(cnt2)
`endif
    );
    aes128_iter_core #(.ROUNDS_PER_CYCLE(10)) dut10 (
        .clock(clock), .reset(reset), .bus(b10), .busy(busy10)
`ifdef AES128_ITER_STATS_EN
        , .blk_count(cnt10)
`endif
    );

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [7];
    int   tests = 0;
    int   fails = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One block through the RPC=1 instance with the sink always ready.
    task automatic run_b1(input logic [127:0] key, input logic [127:0] pt,
                          output logic [127:0] ct, output int lat);
        ct = '0;
        lat = 0;
        b1.in_key = key;
        b1.in_data = pt;
        b1.in_valid = 1'b1;
        b1.out_ready = 1'b1;
        step();
        b1.in_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (b1.out_valid) begin
                ct = b1.out_data;
                lat = k;
                step();
                return;
            end
            step();
        end
    endtask

    initial begin
        logic [127:0] d1, d2, d10, ct;
        int l1, l2, l10, lat, cyc, bi, nout, nacc, seen;
        logic s1, s2, s10;
        int acc [3];
        logic [127:0] got [3];

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                    ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    ct: 128'hf5d3d58503b9699de785895a96fdbaaf};
        vecs[5] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                    ct: 128'h43b1cd7f598ece23881b00e3ed030688};
        vecs[6] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'hf69f2445df4f9b17ad2b417be66c3710,
                    ct: 128'h7b0c785e27e8ad3f8223207104725dd4};

        b1.in_valid = 0;  b1.in_data = '0;  b1.in_key = '0;  b1.out_ready = 0;
        b2.in_valid = 0;  b2.in_data = '0;  b2.in_key = '0;  b2.out_ready = 0;
        b10.in_valid = 0; b10.in_data = '0; b10.in_key = '0; b10.out_ready = 0;

        // Reset state
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        chk("rst_in_ready", 128'(b1.in_ready), 128'd1);
        chk("rst_out_valid", 128'(b1.out_valid), 128'd0);
        chk("rst_out_data", b1.out_data, 128'd0);
        chk("rst_busy", 128'(busy1), 128'd0);
`ifdef AES128_ITER_STATS_EN
        chk("rst_blk_count", 128'(cnt1), 128'd0);
`endif

        // Table: every vector through all three instances, checking ciphertext and latency
        for (int v = 0; v < 7; v++) begin
            b1.in_key = vecs[v].key;  b1.in_data = vecs[v].pt;  b1.in_valid = 1;  b1.out_ready = 1;
            b2.in_key = vecs[v].key;  b2.in_data = vecs[v].pt;  b2.in_valid = 1;  b2.out_ready = 1;
            b10.in_key = vecs[v].key; b10.in_data = vecs[v].pt; b10.in_valid = 1; b10.out_ready = 1;
            step();
            b1.in_valid = 0; b2.in_valid = 0; b10.in_valid = 0;
            s1 = 0; s2 = 0; s10 = 0; l1 = 0; l2 = 0; l10 = 0; d1 = '0; d2 = '0; d10 = '0;
            lat = 1;
            for (int k = 0; k < 20 && !(s1 && s2 && s10); k++) begin
                if (!s1 && b1.out_valid)   begin s1 = 1;  l1 = lat;  d1 = b1.out_data;   end
                if (!s2 && b2.out_valid)   begin s2 = 1;  l2 = lat;  d2 = b2.out_data;   end
                if (!s10 && b10.out_valid) begin s10 = 1; l10 = lat; d10 = b10.out_data; end
                step();
                lat++;
            end
            chk($sformatf("vec%0d_ct_rpc1", v), d1, vecs[v].ct);
            chk($sformatf("vec%0d_ct_rpc2", v), d2, vecs[v].ct);
            chk($sformatf("vec%0d_ct_rpc10", v), d10, vecs[v].ct);
            chk($sformatf("vec%0d_lat_rpc1", v), 128'(l1), 128'd12);
            chk($sformatf("vec%0d_lat_rpc2", v), 128'(l2), 128'd7);
            chk($sformatf("vec%0d_lat_rpc10", v), 128'(l10), 128'd3);
        end

        // Backpressure: hold DONE for 20 cycles
        b1.in_key = vecs[0].key; b1.in_data = vecs[0].pt; b1.in_valid = 1; b1.out_ready = 0;
        step();
        b1.in_valid = 0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (b1.out_valid) seen = 1;
            else step();
        end
        chk("bp_valid_reached", 128'(seen), 128'd1);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("bp_data_c%0d", k), b1.out_data, vecs[0].ct);
            chk($sformatf("bp_in_ready_c%0d", k), 128'(b1.in_ready), 128'd0);
            chk($sformatf("bp_out_valid_c%0d", k), 128'(b1.out_valid), 128'd1);
            step();
        end
        b1.out_ready = 1;
        step();
        chk("bp_after_valid", 128'(b1.out_valid), 128'd0);
        chk("bp_after_in_ready", 128'(b1.in_ready), 128'd1);
        step();
        chk("bp_single_handoff", 128'(b1.out_valid), 128'd0);

        // Reset in ROUND with counter == 4
        b1.in_key = vecs[1].key; b1.in_data = vecs[1].pt; b1.in_valid = 1; b1.out_ready = 1;
        step();
        b1.in_valid = 0;
        for (int k = 0; k < 5; k++) step();
        chk("mid_busy_before_rst", 128'(busy1), 128'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_in_ready", 128'(b1.in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(b1.out_valid), 128'd0);
        chk("mid_rst_out_data", b1.out_data, 128'd0);
        chk("mid_rst_busy", 128'(busy1), 128'd0);
`ifdef AES128_ITER_STATS_EN
        chk("mid_rst_blk_count", 128'(cnt1), 128'd0);
`endif
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (b1.out_valid) seen++;
            step();
        end
        chk("mid_rst_no_output", 128'(seen), 128'd0);
        run_b1(vecs[1].key, vecs[1].pt, ct, lat);
        chk("post_rst_ct", ct, vecs[1].ct);
        chk("post_rst_lat", 128'(lat), 128'd12);

        // Back-to-back: three blocks, in_valid and out_ready held high
        reset = 1'b1;
        step();
        reset = 1'b0;
        bi = 0; nout = 0; cyc = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        got[0] = '0; got[1] = '0; got[2] = '0;
        b1.in_key = vecs[3].key; b1.in_data = vecs[3].pt; b1.in_valid = 1; b1.out_ready = 1;
        while (cyc < 80 && nout < 3) begin
            s1 = b1.in_valid && b1.in_ready;
            if (s1) acc[bi] = cyc;
            if (b1.out_valid && b1.out_ready) begin
                got[nout] = b1.out_data;
                nout++;
            end
            step();
            cyc++;
            if (s1) begin
                bi++;
                if (bi < 3) begin
                    b1.in_key = vecs[3+bi].key;
                    b1.in_data = vecs[3+bi].pt;
                end else begin
                    b1.in_valid = 0;
                end
            end
        end
        chk("b2b_outputs", 128'(nout), 128'd3);
        for (int k = 0; k < 3; k++) chk($sformatf("b2b_ct%0d", k), got[k], vecs[3+k].ct);
        chk("b2b_spacing01", 128'(acc[1] - acc[0]), 128'd13);
        chk("b2b_spacing12", 128'(acc[2] - acc[1]), 128'd13);
`ifdef AES128_ITER_STATS_EN
        chk("b2b_blk_count", 128'(cnt1), 128'd3);
`endif

        // in_valid raised mid-ROUND with a different block: held and taken after handoff
        b1.in_key = vecs[0].key; b1.in_data = vecs[0].pt; b1.in_valid = 1; b1.out_ready = 1;
        step();
        b1.in_valid = 0;
        step(); step(); step();
        b1.in_key = vecs[1].key; b1.in_data = vecs[1].pt; b1.in_valid = 1;
        nout = 0; nacc = 0;
        got[0] = '0; got[1] = '0;
        for (int k = 0; k < 50 && nout < 2; k++) begin
            s1 = b1.in_valid && b1.in_ready;
            if (b1.out_valid && b1.out_ready) begin
                got[nout] = b1.out_data;
                nout++;
            end
            step();
            if (s1) begin
                nacc++;
                b1.in_valid = 0;
            end
        end
        chk("hold_outputs", 128'(nout), 128'd2);
        chk("hold_accepts", 128'(nacc), 128'd1);
        chk("hold_first_ct", got[0], vecs[0].ct);
        chk("hold_second_ct", got[1], vecs[1].ct);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
